// File: rtl/cc_apb_pkg.sv
// Shared types, default constants and the address decode helper for the
// CryptoCell APB slave mux.
package cc_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DSETUP  = 2'd1,
    ST_DACCESS = 2'd2,
    ST_RESP    = 2'd3
  } cc_apb_state_t;

  localparam int unsigned CC_APB_FIELD_W = 12;
  localparam int unsigned CC_APB_MAP_W   = 96;
  localparam logic [15:0] CC_APB_SLV_MAP_DEF = 16'h0821;
  localparam logic [7:0]  CC_APB_TIMEOUT_DEF = 8'd255;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } cc_apb_dec_t;

  // Match the decode field against every map slot; lowest slot wins on duplicates.
  function automatic cc_apb_dec_t cc_apb_decode(input logic [11:0] field,
                                                input logic [95:0] map,
                                                input int unsigned sw,
                                                input int unsigned nslv);
    cc_apb_dec_t res;
    logic [11:0] mask;
    logic [11:0] entry;
    res  = '0;
    mask = 12'((13'd1 << sw) - 13'd1);
    for (int i = 7; i >= 0; i--) begin
      entry = 12'(map >> (32'(i) * sw)) & mask;
      if ((i < int'(nslv)) && ((field & mask) == entry)) begin
        res.hit = 1'b1;
        res.idx = 3'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cc_apb_slave_mux_timeout_cnt.sv
// Hung-slave watchdog: access-cycle counter plus sticky timeout flag.
// Only instantiated when CC_APB_TIMEOUT_EN is defined.
module cc_apb_timeout_cnt #(
  parameter logic [7:0] TIMEOUT_CYC = 8'd255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic to_clr,
  output logic expire_c,
  output logic timeout_flag
);

  logic [7:0] cnt;

  // Fires on the access cycle that would make the wait count reach TIMEOUT_CYC.
  assign expire_c = en && (cnt == (TIMEOUT_CYC - 8'd1));

  // Wait counter, restarted for every downstream transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'd0;
    end else if (clr) begin
      cnt <= 8'd0;
    end else if (en && !expire_c) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Sticky flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_flag <= 1'b0;
    end else if (expire_c) begin
      timeout_flag <= 1'b1;
    end else if (to_clr) begin
      timeout_flag <= 1'b0;
    end
  end

endmodule

// File: rtl/cc_apb_slave_mux.sv
// APB decoder/bridge from the CryptoCell port to NUM_SLV register blocks.
// Optional hung-slave timeout enabled by defining CC_APB_TIMEOUT_EN.
module cc_apb_slave_mux
  import cc_apb_pkg::*;
#(
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned SEL_HI  = 11,
  parameter int unsigned SEL_LO  = 8,
  parameter logic [NUM_SLV*(SEL_HI-SEL_LO+1)-1:0] SLV_MAP = CC_APB_SLV_MAP_DEF,
  parameter logic [7:0]  TIMEOUT_CYC = CC_APB_TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cc_psel,
  input  logic                    cc_penable,
  input  logic                    cc_pwrite,
  input  logic [11:0]             cc_paddr,
  input  logic [31:0]             cc_pwdata,
  output logic [31:0]             cc_prdata,
  output logic                    cc_pready,
  output logic                    cc_pslverr,
  output logic [NUM_SLV-1:0]      slv_psel,
  output logic                    slv_penable,
  output logic                    slv_pwrite,
  output logic [11:0]             slv_paddr,
  output logic [31:0]             slv_pwdata,
  input  logic [NUM_SLV*32-1:0]   slv_prdata,
  input  logic [NUM_SLV-1:0]      slv_pready,
  input  logic [NUM_SLV-1:0]      slv_pslverr
`ifdef CC_APB_TIMEOUT_EN
 ,input  logic                    to_clr,
  output logic                    timeout_flag
`endif
);

  localparam int unsigned SW = SEL_HI - SEL_LO + 1;

  cc_apb_state_t state, state_nxt;
  logic [2:0]         idx_q, idx_nxt;
  logic [NUM_SLV-1:0] psel_nxt;
  logic               penable_nxt, pwrite_nxt, pready_nxt, pslverr_nxt;
  logic [11:0]        paddr_nxt;
  logic [31:0]        pwdata_nxt, prdata_nxt;
  cc_apb_dec_t        dec_c;
  logic               sel_ready_c, sel_err_c, to_expire_c;
  logic [31:0]        sel_rdata_c;

  // Address decode of the upstream setup phase.
  always_comb begin
    dec_c = cc_apb_decode(12'(cc_paddr[SEL_HI:SEL_LO]), 96'(SLV_MAP), SW, NUM_SLV);
  end

  // Return-path mux: only the selected slot is observed.
  always_comb begin
    sel_ready_c = 1'b0;
    sel_err_c   = 1'b0;
    sel_rdata_c = '0;
    for (int i = 0; i < int'(NUM_SLV); i++) begin
      if (idx_q == 3'(i)) begin
        sel_ready_c = slv_pready[i];
        sel_err_c   = slv_pslverr[i];
        sel_rdata_c = slv_prdata[i*32 +: 32];
      end
    end
  end

`ifdef CC_APB_TIMEOUT_EN
  cc_apb_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_to (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (state == ST_DSETUP),
    .en           ((state == ST_DACCESS) && !sel_ready_c),
    .to_clr       (to_clr),
    .expire_c     (to_expire_c),
    .timeout_flag (timeout_flag)
  );
`else
  logic [7:0] unused_timeout_cyc;
  assign unused_timeout_cyc = TIMEOUT_CYC;
  assign to_expire_c = 1'b0;
`endif

  // Next-state and next-output logic; everything defaults to idle/zero.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx_q;
    psel_nxt    = '0;
    penable_nxt = 1'b0;
    pwrite_nxt  = 1'b0;
    paddr_nxt   = '0;
    pwdata_nxt  = '0;
    prdata_nxt  = '0;
    pready_nxt  = 1'b0;
    pslverr_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cc_psel && !cc_penable) begin
          if (dec_c.hit) begin
            state_nxt  = ST_DSETUP;
            idx_nxt    = dec_c.idx;
            psel_nxt   = NUM_SLV'(1) << dec_c.idx;
            pwrite_nxt = cc_pwrite;
            paddr_nxt  = cc_paddr;
            pwdata_nxt = cc_pwdata;
          end else begin
            state_nxt   = ST_RESP;
            pready_nxt  = 1'b1;
            pslverr_nxt = 1'b1;
          end
        end
      end
      ST_DSETUP: begin
        state_nxt   = ST_DACCESS;
        psel_nxt    = slv_psel;
        penable_nxt = 1'b1;
        pwrite_nxt  = slv_pwrite;
        paddr_nxt   = slv_paddr;
        pwdata_nxt  = slv_pwdata;
      end
      ST_DACCESS: begin
        if (sel_ready_c) begin
          state_nxt   = ST_RESP;
          pready_nxt  = 1'b1;
          prdata_nxt  = slv_pwrite ? 32'd0 : sel_rdata_c;
          pslverr_nxt = sel_err_c;
        end else if (to_expire_c) begin
          state_nxt   = ST_RESP;
          pready_nxt  = 1'b1;
          pslverr_nxt = 1'b1;
        end else begin
          psel_nxt    = slv_psel;
          penable_nxt = 1'b1;
          pwrite_nxt  = slv_pwrite;
          paddr_nxt   = slv_paddr;
          pwdata_nxt  = slv_pwdata;
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx_q       <= 3'd0;
      slv_psel    <= '0;
      slv_penable <= 1'b0;
      slv_pwrite  <= 1'b0;
      slv_paddr   <= '0;
      slv_pwdata  <= '0;
      cc_prdata   <= '0;
      cc_pready   <= 1'b0;
      cc_pslverr  <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx_q       <= idx_nxt;
      slv_psel    <= psel_nxt;
      slv_penable <= penable_nxt;
      slv_pwrite  <= pwrite_nxt;
      slv_paddr   <= paddr_nxt;
      slv_pwdata  <= pwdata_nxt;
      cc_prdata   <= prdata_nxt;
      cc_pready   <= pready_nxt;
      cc_pslverr  <= pslverr_nxt;
    end
  end

endmodule

// File: tb/tb_cc_apb_slave_mux.sv
// Directed bench for cc_apb_slave_mux: vector table plus reset and
// (with CC_APB_TIMEOUT_EN) timeout sequences.
module tb_cc_apb_slave_mux;

  localparam logic [127:0] SLOT_DATA =
    {32'h0BADC0DE, 32'hCAFEF00D, 32'h11112222, 32'hDEADBEEF};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cc_psel, cc_penable, cc_pwrite;
  logic [11:0]  cc_paddr;
  logic [31:0]  cc_pwdata, cc_prdata;
  logic         cc_pready, cc_pslverr;
  logic [3:0]   slv_psel;
  logic         slv_penable, slv_pwrite;
  logic [11:0]  slv_paddr;
  logic [31:0]  slv_pwdata;
  logic [127:0] slv_prdata;
  logic [3:0]   slv_pready, slv_pslverr;
  logic         to_clr;
  logic         timeout_flag;
  logic         flag_at_resp;

  int   tests = 0;
  int   fails = 0;
  int   wcnt  = 0;
  int   cfg_slot, cfg_wait;
  logic cfg_err, oth_rdy, oth_err;

  typedef struct {
    string       name;
    logic [11:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          slot;
    int          wait_c;
    logic        err;
    logic        oth_rdy;
    logic        oth_err;
    logic [3:0]  exp_psel;
    int          exp_lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  cc_apb_slave_mux #(.TIMEOUT_CYC(8'd4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cc_psel     (cc_psel),
    .cc_penable  (cc_penable),
    .cc_pwrite   (cc_pwrite),
    .cc_paddr    (cc_paddr),
    .cc_pwdata   (cc_pwdata),
    .cc_prdata   (cc_prdata),
    .cc_pready   (cc_pready),
    .cc_pslverr  (cc_pslverr),
    .slv_psel    (slv_psel),
    .slv_penable (slv_penable),
    .slv_pwrite  (slv_pwrite),
    .slv_paddr   (slv_paddr),
    .slv_pwdata  (slv_pwdata),
    .slv_prdata  (slv_prdata),
    .slv_pready  (slv_pready),
    .slv_pslverr (slv_pslverr)
`ifdef CC_APB_TIMEOUT_EN
   ,.to_clr      (to_clr),
    .timeout_flag(timeout_flag)
`endif
  );

`ifndef CC_APB_TIMEOUT_EN
  assign timeout_flag = 1'b0;
`endif

  always #5 clk = ~clk;

  // Slave model: selected slot waits cfg_wait access cycles, others use fixed levels.
  always @(posedge clk) wcnt <= slv_penable ? wcnt + 1 : 0;

  always_comb begin
    slv_prdata = SLOT_DATA;
    for (int i = 0; i < 4; i++) begin
      slv_pready[i]  = (i == cfg_slot) ? (wcnt >= cfg_wait) : oth_rdy;
      slv_pslverr[i] = (i == cfg_slot) ? cfg_err : oth_err;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One complete upstream transfer with cycle-accurate checks.
  task automatic run_vec(input vec_t v);
    int  k;
    bit  got;
    cfg_slot = v.slot; cfg_wait = v.wait_c; cfg_err = v.err;
    oth_rdy  = v.oth_rdy; oth_err = v.oth_err;
    @(negedge clk);
    cc_psel = 1'b1; cc_penable = 1'b0; cc_pwrite = v.wr;
    cc_paddr = v.addr; cc_pwdata = v.wdata;
    @(posedge clk);
    #1 cc_penable = 1'b1;
    k = 0; got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        chk({v.name, " psel"}, 64'(slv_psel), 64'(v.exp_psel));
        chk({v.name, " paddr"}, 64'(slv_paddr), (v.exp_psel != 0) ? 64'(v.addr) : 64'd0);
        chk({v.name, " pwdata"}, 64'(slv_pwdata), (v.exp_psel != 0) ? 64'(v.wdata) : 64'd0);
      end
      if (k == 2 && v.exp_psel != 0)
        chk({v.name, " penable"}, 64'({slv_psel, slv_penable, slv_pwrite}),
            64'({v.exp_psel, 1'b1, v.wr}));
      if (cc_pready) begin
        got = 1'b1;
        chk({v.name, " latency"}, 64'(k), 64'(v.exp_lat));
        chk({v.name, " prdata"}, 64'(cc_prdata), 64'(v.exp_rdata));
        chk({v.name, " pslverr"}, 64'(cc_pslverr), 64'(v.exp_err));
        flag_at_resp = timeout_flag;
        to_clr = 1'b0;
        cc_psel = 1'b0; cc_penable = 1'b0;
      end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s: no cc_pready within 40 cycles", v.name);
      cc_psel = 1'b0; cc_penable = 1'b0;
    end
    @(negedge clk);
    chk({v.name, " post_resp"}, 64'({cc_pready, cc_pslverr, cc_prdata, slv_psel, slv_penable}), 64'd0);
  endtask

  initial begin
    vec_t tv;
    vecs[0] = '{"rd_slot0",   12'h104, 1'b0, 32'h0000_0104, 0, 0,  1'b0, 1'b0, 1'b0, 4'b0001, 3, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{"wr_slot2",   12'h824, 1'b1, 32'h5A5A_0001, 2, 3,  1'b0, 1'b1, 1'b0, 4'b0100, 6, 32'h0,        1'b0};
    vecs[2] = '{"unmapped_f", 12'hF00, 1'b0, 32'h0,         0, 0,  1'b0, 1'b1, 1'b0, 4'b0000, 1, 32'h0,        1'b1};
    vecs[3] = '{"err_slot1",  12'h2A0, 1'b0, 32'h0000_0777, 1, 0,  1'b1, 1'b0, 1'b0, 4'b0010, 3, 32'h11112222, 1'b1};
    vecs[4] = '{"rd_slot3",   12'h0FC, 1'b0, 32'h1234_5678, 3, 1,  1'b0, 1'b1, 1'b1, 4'b1000, 4, 32'h0BADC0DE, 1'b0};
    vecs[5] = '{"unmapped_3", 12'h3FF, 1'b1, 32'hFFFF_FFFF, 0, 0,  1'b0, 1'b1, 1'b0, 4'b0000, 1, 32'h0,        1'b1};
    vecs[6] = '{"edge_wait3", 12'h1F0, 1'b0, 32'h0,         0, 3,  1'b0, 1'b0, 1'b0, 4'b0001, 6, 32'hDEADBEEF, 1'b0};

    rst_n = 1'b0; cc_psel = 1'b0; cc_penable = 1'b0; cc_pwrite = 1'b0;
    cc_paddr = '0; cc_pwdata = '0; to_clr = 1'b0; flag_at_resp = 1'b0;
    cfg_slot = 0; cfg_wait = 0; cfg_err = 1'b0; oth_rdy = 1'b0; oth_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", 64'({cc_pready, cc_pslverr, slv_psel, slv_penable, slv_pwrite, slv_paddr, timeout_flag}), 64'd0);
    chk("reset_data", 64'({cc_prdata, slv_pwdata}), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);
    chk("no_timeout_on_boundary", 64'(timeout_flag), 64'd0);

    // Reset asserted while the downstream access is pending.
    cfg_slot = 2; cfg_wait = 100; cfg_err = 1'b0; oth_rdy = 1'b0; oth_err = 1'b0;
    @(negedge clk);
    cc_psel = 1'b1; cc_penable = 1'b0; cc_pwrite = 1'b0; cc_paddr = 12'h810; cc_pwdata = 32'h0;
    @(posedge clk);
    #1 cc_penable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_access", 64'({slv_psel, slv_penable, slv_paddr}), 64'({4'b0100, 1'b1, 12'h810}));
    #2 rst_n = 1'b0;
    #1 chk("rst_async_ctrl", 64'({cc_pready, cc_pslverr, slv_psel, slv_penable, slv_pwrite, slv_paddr}), 64'd0);
    chk("rst_async_data", 64'({cc_prdata, slv_pwdata}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; cc_psel = 1'b0; cc_penable = 1'b0;
    tv = vecs[0]; tv.name = "rd_after_rst";
    run_vec(tv);

`ifdef CC_APB_TIMEOUT_EN
    tv = '{"timeout1", 12'h108, 1'b0, 32'h0, 0, 1000, 1'b0, 1'b1, 1'b0, 4'b0001, 6, 32'h0, 1'b1};
    run_vec(tv);
    chk("to_flag_set", 64'(flag_at_resp), 64'd1);
    chk("to_flag_sticky", 64'(timeout_flag), 64'd1);
    to_clr = 1'b1;
    @(negedge clk);
    to_clr = 1'b0;
    chk("to_flag_clr", 64'(timeout_flag), 64'd0);
    to_clr = 1'b1;
    tv.name = "timeout2";
    run_vec(tv);
    chk("to_set_beats_clr", 64'(flag_at_resp), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cc_apb_slave_mux.md
# cc_apb_slave_mux

Parametrised APB slave-side decoder and bridge between the CryptoCell APB port (`cc_*`) and NUM_SLV internal register blocks (TRNG, crypto control, ...). It decodes a configurable address field into a one-hot downstream select and re-times every transfer through a registered FSM. It adds wait-state support (`slv_pready`), error propagation (`slv_pslverr`), decode errors for unmapped regions, and an optional hung-slave timeout. Upstream read data, ready and error are all registered.

## Interface
- NUM_SLV, 4, number of downstream slaves (1..8)
- SEL_HI, 11, MSB of decode field in `cc_paddr`
- SEL_LO, 8, LSB of decode field; field width SW = SEL_HI-SEL_LO+1
- SLV_MAP, 16'h0821, slot i is selected when the decode field equals SLV_MAP[i*SW +: SW]; with defaults, slot0=1 (TRNG), slot1=2, slot2=8 (crypto ctl), slot3=0; lowest slot wins on duplicate entries
- TIMEOUT_CYC, 8'd255, access-phase cycles before abort (1..255)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cc_psel  in  1  upstream select
- cc_penable  in  1  upstream enable
- cc_pwrite  in  1  upstream write
- cc_paddr  in  12  upstream address
- cc_pwdata  in  32  upstream write data
- cc_prdata  out  32  registered read data
- cc_pready  out  1  registered transfer-complete
- cc_pslverr  out  1  registered error
- slv_psel  out  NUM_SLV  one-hot downstream select
- slv_penable  out  1  downstream enable
- slv_pwrite  out  1  downstream write
- slv_paddr  out  12  downstream address; 0 when no slave selected
- slv_pwdata  out  32  downstream write data; 0 when no slave selected
- slv_prdata  in  NUM_SLV*32  per-slave read data, slot i at [i*32 +: 32]
- slv_pready  in  NUM_SLV  per-slave ready
- slv_pslverr  in  NUM_SLV  per-slave error
- to_clr  in  1  clears `timeout_flag` (present only with CC_APB_TIMEOUT_EN)
- timeout_flag  out  1  sticky timeout indicator (present only with CC_APB_TIMEOUT_EN)

## Operation
- FSM states are IDLE, DSETUP, DACCESS and RESP. All outputs reset to 0, and the FSM resets to IDLE.
- IDLE:
  - On `cc_psel & !cc_penable` (upstream setup), decode `cc_paddr[SEL_HI:SEL_LO]` against SLV_MAP.
  - On a hit: register slot index, `cc_paddr`, `cc_pwdata`, `cc_pwrite`, then go to DSETUP.
  - On a miss: go to RESP with error=1 and data=0.
- DSETUP:
  - `slv_psel[idx]`=1, `slv_penable`=0, address/data/write driven from registers.
  - Always go to DACCESS.
- DACCESS:
  - `slv_psel[idx]`=1, `slv_penable`=1.
  - On `slv_pready[idx]`: capture `slv_prdata` slot idx into `cc_prdata`. On a write, `cc_prdata` is forced to 0. Capture `slv_pslverr[idx]` into `cc_pslverr`, then go to RESP.
  - Otherwise increment the wait counter (timeout below).
- RESP:
  - `cc_pready`=1 for exactly one cycle; downstream outputs return to 0.
  - Go to IDLE. `cc_prdata`/`cc_pslverr` clear to 0 on the cycle after RESP.
- `cc_pready` is low at all times outside RESP, so upstream wait states are inserted automatically.
- Only `slv_pready`/`slv_pslverr` of the selected slot are observed; other slots are ignored.
- Upstream `cc_psel` deasserted mid-transfer (protocol violation):
  - An in-flight downstream transfer still completes.
  - The RESP cycle is still issued and its response is discarded by the master.
  - No new setup is accepted until IDLE.
- Back-to-back transfers: a new upstream setup is accepted only in IDLE. The minimum spacing is therefore one IDLE cycle between transfers.

## Timing
- Upstream setup at cycle T, mapped slave:
  - DSETUP at T+1.
  - DACCESS at T+2.
  - If the slave is ready at T+2, RESP (`cc_pready`=1) at T+3.
  - This is 2 upstream wait states; each downstream wait adds 1.
- Unmapped address: RESP at T+1 with `cc_pslverr`=1 and `cc_prdata`=0 (0 wait states).
- Timeout, with CC_APB_TIMEOUT_EN:
  - An 8-bit counter is cleared on DSETUP entry and increments each DACCESS cycle without ready.
  - When the count reaches TIMEOUT_CYC without ready: drop `slv_psel`/`slv_penable` and go to RESP with error=1, data=0. `timeout_flag` sets the same cycle.
  - `slv_pready[idx]` in the same cycle as the count reaching TIMEOUT_CYC counts as ready; the normal response is returned and there is no timeout.
  - `to_clr` and a new timeout in the same cycle: set wins.
- Reset asserted mid-transfer: all outputs go to 0 immediately (async), and the FSM returns to IDLE with no response.

## Configuration
- CC_APB_TIMEOUT_EN defined:
  - Timeout counter, `to_clr` and `timeout_flag` are present.
  - A hung slave is aborted after TIMEOUT_CYC access cycles.
- Not defined:
  - No counter and no timeout ports.
  - DACCESS waits indefinitely for `slv_pready[idx]`.

## Structure
- Package `cc_apb_pkg` holds:
  - FSM state enum `cc_apb_state_t`.
  - Default SLV_MAP/TIMEOUT constants.
  - Decode function: field plus map to hit and index.
- One sub-module, `cc_apb_timeout_cnt`: counter with clear, enable and expire output, plus the sticky flag with clr. It is instantiated only under CC_APB_TIMEOUT_EN.

## Test plan
- Read `cc_paddr`=12'h104, slot0 `slv_prdata`=32'hDEADBEEF, `slv_pready` tied high:
  - `slv_psel`=4'b0001 at T+1, `slv_penable` at T+2.
  - `cc_pready`=1, `cc_prdata`=32'hDEADBEEF, `cc_pslverr`=0 at T+3.
- Write 12'h824 with data 32'h5A5A0001, slot2 pready low for 3 cycles:
  - `slv_paddr`=12'h824, `slv_pwdata`=32'h5A5A0001, `slv_psel`=4'b0100.
  - `cc_pready` at T+6, `cc_prdata`=0.
- Access 12'h F00 (unmapped):
  - `cc_pready`=1, `cc_pslverr`=1, `cc_prdata`=0 at T+1.
  - `slv_psel` stays 0.
- Slot1 `slv_pslverr`=1 with ready at T+2: `cc_pslverr`=1 at T+3.
- CC_APB_TIMEOUT_EN, TIMEOUT_CYC=4, slave never ready:
  - Abort, `cc_pready`+`cc_pslverr` after 4 DACCESS cycles, `timeout_flag`=1.
  - `to_clr` pulse clears the flag; `to_clr` coincident with a second timeout leaves the flag 1.
- `rst_n` low during DACCESS:
  - All outputs 0 asynchronously.
  - After release, the next read completes normally at T+3.
